// File: rtl/gamma_rgb_sequencer.sv
// Gamma-corrected RGB PWM driver.
// One external LUT is shared by the three colour channels, one channel per
// cycle. The corrected duties are double-buffered: they load at the end of a
// PWM period so that no period is ever output with a partly updated duty.
module gamma_rgb_sequencer #(
    parameter int PRESCALE = 1,
    parameter bit INVERT   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic [23:0] pixel_data,
    output logic [7:0]  lut_value,
    input  logic [7:0]  lut_corrected,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        CH_R,
        CH_G,
        CH_B,
        COMMIT
    } state_t;

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    state_t      state;
    state_t      state_next;
    logic [23:0] pixel;
    logic [7:0]  shadow_r;
    logic [7:0]  shadow_g;
    logic [7:0]  shadow_b;
    logic [7:0]  duty_r;
    logic [7:0]  duty_g;
    logic [7:0]  duty_b;
    logic [7:0]  cnt;
    logic [15:0] prescaler;
    logic        tick;
    logic        period_end;
    logic        transfer;

    assign tick        = (prescaler == PRESCALE_LAST);
    assign period_end  = tick && (cnt == 8'hFF);
    assign pixel_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign transfer    = pixel_valid && pixel_ready;

    // Free-running prescaler and 8-bit PWM counter; the counter advances once per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= 16'd0;
            cnt       <= 8'd0;
        end else if (tick) begin
            prescaler <= 16'd0;
            cnt       <= cnt + 8'd1;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, plus the LUT address, which carries the channel served in this cycle.
    always_comb begin
        state_next = state;
        lut_value  = 8'h00;
        case (state)
            IDLE: begin
                if (pixel_valid) begin
                    state_next = CH_R;
                end
            end
            CH_R: begin
                lut_value  = pixel[23:16];
                state_next = CH_G;
            end
            CH_G: begin
                lut_value  = pixel[15:8];
                state_next = CH_B;
            end
            CH_B: begin
                lut_value  = pixel[7:0];
                state_next = COMMIT;
            end
            COMMIT: begin
                if (period_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pixel latch, per-channel shadow capture, and duty commit at the period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel    <= 24'h000000;
            shadow_r <= 8'h00;
            shadow_g <= 8'h00;
            shadow_b <= 8'h00;
            duty_r   <= 8'h00;
            duty_g   <= 8'h00;
            duty_b   <= 8'h00;
        end else begin
            if (transfer) begin
                pixel <= pixel_data;
            end
            case (state)
                CH_R: shadow_r <= lut_corrected;
                CH_G: shadow_g <= lut_corrected;
                CH_B: shadow_b <= lut_corrected;
                COMMIT: begin
                    if (period_end) begin
                        duty_r <= shadow_r;
                        duty_g <= shadow_g;
                        duty_b <= shadow_b;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered PWM comparators; a reset value of INVERT keeps the LEDs dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r <= INVERT;
            pwm_g <= INVERT;
            pwm_b <= INVERT;
        end else begin
            pwm_r <= (cnt < duty_r) ^ INVERT;
            pwm_g <= (cnt < duty_g) ^ INVERT;
            pwm_b <= (cnt < duty_b) ^ INVERT;
        end
    end

endmodule
